// File: rtl/bp_be_slot_ckpt_fifo_pkg.sv
// Shared definitions for the slot-granular checkpoint FIFO.
//   - Default geometry (payload width, packet entries, sub-slots per packet).
//   - ptr_op_e: the one operation a slot pointer performs in a cycle.
//   - ptr_op_decode: fixes the priority between those operations.
package bp_be_slot_ckpt_fifo_pkg;

  localparam int unsigned DefDataWidth = 64;
  localparam int unsigned DefEls       = 8;
  localparam int unsigned DefSlots     = 4;

  typedef enum logic [1:0] {
    PtrHold,
    PtrClr,
    PtrSet,
    PtrAdd
  } ptr_op_e;

  // Clear beats load, load beats advance. A zero-count advance is a hold.
  function automatic ptr_op_e ptr_op_decode(input logic clr, input logic set, input logic add);
    if (clr) begin
      return PtrClr;
    end else if (set) begin
      return PtrSet;
    end else if (add) begin
      return PtrAdd;
    end
    return PtrHold;
  endfunction

endpackage

// File: rtl/bp_be_slot_ckpt_fifo_if.sv
// FE->BE packet queue interface.
//   master: the side that drives the queue (write, read, commit, clear, roll-back).
//   slave : the queue itself.
// Write side : v_i, data_i, ready_and_o
// Read side  : v_o, data_o, slot_o, read_i, read_cnt_i
// Checkpoint : cmt_i, cmt_cnt_i, roll_i, clr_i
// Status     : count_o (commit..write packets), inflight_o (commit..read packets)
interface bp_be_slot_ckpt_fifo_if
  import bp_be_slot_ckpt_fifo_pkg::*;
#(
  parameter int unsigned data_width_p = DefDataWidth,
  parameter int unsigned els_p        = DefEls,
  parameter int unsigned slots_p      = DefSlots
);
  localparam int unsigned SlotW = $clog2(slots_p);
  localparam int unsigned CntW  = SlotW + 1;
  localparam int unsigned PktW  = $clog2(els_p) + 1;

  logic                    clr_i;
  logic                    roll_i;
  logic                    v_i;
  logic [data_width_p-1:0] data_i;
  logic                    ready_and_o;
  logic                    v_o;
  logic [data_width_p-1:0] data_o;
  logic [SlotW-1:0]        slot_o;
  logic                    read_i;
  logic [CntW-1:0]         read_cnt_i;
  logic                    cmt_i;
  logic [CntW-1:0]         cmt_cnt_i;
  logic [PktW-1:0]         count_o;
  logic [PktW-1:0]         inflight_o;

  modport master (
    output clr_i, roll_i, v_i, data_i, read_i, read_cnt_i, cmt_i, cmt_cnt_i,
    input  ready_and_o, v_o, data_o, slot_o, count_o, inflight_o
  );

  modport slave (
    input  clr_i, roll_i, v_i, data_i, read_i, read_cnt_i, cmt_i, cmt_cnt_i,
    output ready_and_o, v_o, data_o, slot_o, count_o, inflight_o
  );

endinterface

// File: rtl/bp_be_slot_ckpt_fifo_ptr.sv
// Wrapping {wrap, mem, slot} pointer register.
//   clk_i, reset_n_i : clock, asynchronous active-low reset (pointer -> 0)
//   clr_i            : pointer -> 0
//   set_i, set_ptr_i : load set_ptr_i
//   add_i, add_cnt_i : advance by add_cnt_i sub-slots; reaching or passing the end of the
//                      packet moves to slot 0 of the next packet (leftover is discarded)
//   ptr_r_o          : current pointer
//   ptr_n_o          : pointer after this cycle's update
module bp_be_slot_ckpt_fifo_ptr
  import bp_be_slot_ckpt_fifo_pkg::*;
#(
  parameter int unsigned mem_w_p  = 3,
  parameter int unsigned slot_w_p = 2,
  localparam int unsigned PtrW    = mem_w_p + slot_w_p + 1,
  localparam int unsigned CntW    = slot_w_p + 1
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  input  logic            clr_i,
  input  logic            set_i,
  input  logic [PtrW-1:0] set_ptr_i,
  input  logic            add_i,
  input  logic [CntW-1:0] add_cnt_i,
  output logic [PtrW-1:0] ptr_r_o,
  output logic [PtrW-1:0] ptr_n_o
);

  localparam logic [CntW-1:0]    Slots  = CntW'(1 << slot_w_p);
  localparam logic [mem_w_p:0]   PktOne = (mem_w_p + 1)'(1);

  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [mem_w_p:0]    pkt_q, pkt_inc;
  logic [slot_w_p-1:0] slot_q;
  logic [CntW-1:0]     slot_sum;
  ptr_op_e             op;

  assign pkt_q    = ptr_q[PtrW-1:slot_w_p];
  assign slot_q   = ptr_q[slot_w_p-1:0];
  assign pkt_inc  = pkt_q + PktOne;
  assign slot_sum = {1'b0, slot_q} + add_cnt_i;

  always_comb begin
    op = ptr_op_decode(clr_i, set_i, add_i & (|add_cnt_i));
  end

  always_comb begin
    ptr_d = ptr_q;
    unique case (op)
      PtrClr: ptr_d = '0;
      PtrSet: ptr_d = set_ptr_i;
      PtrAdd: begin
        if (slot_sum >= Slots) begin
          ptr_d = {pkt_inc, {slot_w_p{1'b0}}};
        end else begin
          ptr_d = {pkt_q, slot_sum[slot_w_p-1:0]};
        end
      end
      default: ptr_d = ptr_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_r_o = ptr_q;
  assign ptr_n_o = ptr_d;

endmodule

// File: rtl/bp_be_slot_ckpt_fifo.sv
// Checkpointing FE->BE packet queue with sub-slot-granular reads and commits.
// Each entry holds one fetch packet of slots_p sub-slots. Three pointers:
//   write  : next entry to fill (always packet aligned)
//   read   : next sub-slot handed to issue/pre-decode
//   commit : oldest sub-slot not yet retired; space frees only when commit moves on
// roll_i rewinds read to commit (after this cycle's commit); clr_i empties everything.
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   fifo_if          : slave side of bp_be_slot_ckpt_fifo_if (handshake, data, status)
// Build option:
//   BP_BE_SLOT_CKPT_FIFO_BYPASS_EN - when defined, a packet written into an empty queue is
//   presented on v_o/data_o in the same cycle and may be read in that cycle.
module bp_be_slot_ckpt_fifo
  import bp_be_slot_ckpt_fifo_pkg::*;
#(
  parameter int unsigned data_width_p = DefDataWidth,
  parameter int unsigned els_p        = DefEls,
  parameter int unsigned slots_p      = DefSlots
) (
  input logic                   clk_i,
  input logic                   reset_n_i,
  bp_be_slot_ckpt_fifo_if.slave fifo_if
);

  localparam int unsigned MemW  = $clog2(els_p);
  localparam int unsigned SlotW = $clog2(slots_p);
  localparam int unsigned PktW  = MemW + 1;
  localparam int unsigned PtrW  = PktW + SlotW;
  localparam int unsigned CntW  = SlotW + 1;

  logic [PtrW-1:0]         wptr_q, wptr_n, rptr_q, rptr_n, cptr_q, cptr_n;
  logic [PktW-1:0]         count_q, count_d, inflight_q, inflight_d;
  logic [MemW-1:0]         wr_addr, rd_addr;
  logic                    full, empty, write_en, read_en, v_o;
  logic [data_width_p-1:0] mem_q [els_p];
  logic [data_width_p-1:0] mem_rdata, data_o;

  assign wr_addr = wptr_q[PtrW-2:SlotW];
  assign rd_addr = rptr_q[PtrW-2:SlotW];

  // count_q is exactly commit..write in packets, so it doubles as the full flag.
  assign full     = (count_q == PktW'(els_p));
  // Write pointer slot is always 0, so a whole-pointer compare is the empty test.
  assign empty    = (rptr_q == wptr_q);
  assign write_en = fifo_if.v_i & ~full & ~fifo_if.clr_i;
  assign read_en  = v_o & fifo_if.read_i;

  always_ff @(posedge clk_i) begin
    if (write_en) begin
      mem_q[wr_addr] <= fifo_if.data_i;
    end
  end

  assign mem_rdata = mem_q[rd_addr];

`ifdef BP_BE_SLOT_CKPT_FIFO_BYPASS_EN
  logic bypass;
  // Empty can coexist with full (all read, nothing committed), hence the ~full term.
  assign bypass = empty & fifo_if.v_i & ~full;
  assign v_o    = ~empty | bypass;
  assign data_o = bypass ? fifo_if.data_i : mem_rdata;
`else
  assign v_o    = ~empty;
  assign data_o = mem_rdata;
`endif

  bp_be_slot_ckpt_fifo_ptr #(
    .mem_w_p  (MemW),
    .slot_w_p (SlotW)
  ) u_wptr (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clr_i     (fifo_if.clr_i),
    .set_i     (1'b0),
    .set_ptr_i ('0),
    .add_i     (write_en),
    .add_cnt_i (CntW'(slots_p)),
    .ptr_r_o   (wptr_q),
    .ptr_n_o   (wptr_n)
  );

  bp_be_slot_ckpt_fifo_ptr #(
    .mem_w_p  (MemW),
    .slot_w_p (SlotW)
  ) u_cptr (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clr_i     (fifo_if.clr_i),
    .set_i     (1'b0),
    .set_ptr_i ('0),
    .add_i     (fifo_if.cmt_i),
    .add_cnt_i (fifo_if.cmt_cnt_i),
    .ptr_r_o   (cptr_q),
    .ptr_n_o   (cptr_n)
  );

  // Roll-back loads the post-commit value so a same-cycle commit is not lost.
  bp_be_slot_ckpt_fifo_ptr #(
    .mem_w_p  (MemW),
    .slot_w_p (SlotW)
  ) u_rptr (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clr_i     (fifo_if.clr_i),
    .set_i     (fifo_if.roll_i),
    .set_ptr_i (cptr_n),
    .add_i     (read_en),
    .add_cnt_i (fifo_if.read_cnt_i),
    .ptr_r_o   (rptr_q),
    .ptr_n_o   (rptr_n)
  );

  assign count_d    = wptr_n[PtrW-1:SlotW] - cptr_n[PtrW-1:SlotW];
  assign inflight_d = rptr_n[PtrW-1:SlotW] - cptr_n[PtrW-1:SlotW];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q    <= '0;
      inflight_q <= '0;
    end else begin
      count_q    <= count_d;
      inflight_q <= inflight_d;
    end
  end

  assign fifo_if.ready_and_o = ~full;
  assign fifo_if.v_o         = v_o;
  assign fifo_if.data_o      = data_o;
  assign fifo_if.slot_o      = rptr_q[SlotW-1:0];
  assign fifo_if.count_o     = count_q;
  assign fifo_if.inflight_o  = inflight_q;

  // Sub-slot distances measured from the commit pointer; read must never lead write,
  // and commit must never pass read.
  logic [PtrW-1:0] rd_ahead_n, wr_ahead_n, rd_ahead_q, wr_ahead_q;
  assign rd_ahead_n = rptr_n - cptr_n;
  assign wr_ahead_n = wptr_n - cptr_n;
  assign rd_ahead_q = rptr_q - cptr_q;
  assign wr_ahead_q = wptr_q - cptr_q;

  cmt_past_read_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    rd_ahead_n <= wr_ahead_n);
  ptr_order_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    rd_ahead_q <= wr_ahead_q);

endmodule

// File: tb/tb_bp_be_slot_ckpt_fifo.sv
module tb_bp_be_slot_ckpt_fifo;

  localparam int unsigned Dw    = 64;
  localparam int unsigned Els   = 8;
  localparam int unsigned Slots = 4;

  logic clk;
  logic rst_n;

  bp_be_slot_ckpt_fifo_if #(.data_width_p(Dw), .els_p(Els), .slots_p(Slots)) f ();

  bp_be_slot_ckpt_fifo #(
    .data_width_p (Dw),
    .els_p        (Els),
    .slots_p      (Slots)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .fifo_if   (f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          clr, roll, v;
    logic [63:0] d;
    bit          rd;
    int          rc;
    bit          cm;
    int          cc;
    bit          ev;
    logic [63:0] ed;
    int          es;
    bit          er;
    int          ec;
    int          ei;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit clr, bit roll, bit v, logic [63:0] d, bit rd, int rc,
                              bit cm, int cc, bit ev, logic [63:0] ed, int es, bit er,
                              int ec, int ei);
    vec_t t;
    t = '{clr, roll, v, d, rd, rc, cm, cc, ev, ed, es, er, ec, ei};
    vecs.push_back(t);
  endfunction

  task automatic idle();
    f.clr_i = 0; f.roll_i = 0; f.v_i = 0; f.data_i = '0;
    f.read_i = 0; f.read_cnt_i = '0; f.cmt_i = 0; f.cmt_cnt_i = '0;
  endtask

  task automatic drive(input vec_t t);
    f.clr_i = t.clr; f.roll_i = t.roll; f.v_i = t.v; f.data_i = t.d;
    f.read_i = t.rd; f.read_cnt_i = 3'(t.rc); f.cmt_i = t.cm; f.cmt_cnt_i = 3'(t.cc);
  endtask

  task automatic check_out(input string name, input int idx, input bit ev,
                           input logic [63:0] ed, input int es, input bit er,
                           input int ec, input int ei);
    bit ok;
    checks++;
    ok = (f.v_o === ev) && (f.slot_o === 2'(es)) && (f.ready_and_o === er) &&
         (f.count_o === 4'(ec)) && (f.inflight_o === 4'(ei)) && (!ev || f.data_o === ed);
    if (!ok) begin
      errors++;
      $display("FAIL %s[%0d]: got v=%0b d=%h s=%0d rdy=%0b cnt=%0d inf=%0d; exp v=%0b d=%h s=%0d rdy=%0b cnt=%0d inf=%0d",
               name, idx, f.v_o, f.data_o, f.slot_o, f.ready_and_o, f.count_o, f.inflight_o,
               ev, ed, es, er, ec, ei);
    end
  endtask

  // Scoreboard: packets from commit onward, read offset in packets, slots inside packets.
  logic [63:0] q[$];
  int r_off, r_slot, c_slot;

  initial begin
    // Fill: to full, 9th dropped, read all, commit all (pointers wrap to 8).
    for (int i = 0; i < 8; i++)
      add(0, 0, 1, 64'h100 + i, 0, 0, 0, 0, 1, 64'h100, 0, (i < 7), i + 1, 0);
    add(0, 0, 1, 64'h108, 0, 0, 0, 0, 1, 64'h100, 0, 0, 8, 0);
    for (int k = 0; k < 8; k++)
      add(0, 0, 0, 0, 1, 4, 0, 0, (k < 7), 64'h101 + k, 0, 0, 8, k + 1);
    for (int j = 0; j < 8; j++)
      add(0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 1, 7 - j, 7 - j);
    // Sub-slot reads 1,1,2, zero counts and read-while-empty are no-ops.
    add(0, 0, 1, 64'hA, 0, 0, 0, 0, 1, 64'hA, 0, 1, 1, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 1, 64'hA, 0, 1, 1, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0, 1, 64'hA, 1, 1, 1, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0, 1, 64'hA, 2, 1, 1, 0);
    add(0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 1, 1, 1);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    // Roll-back, then roll with same-cycle commit 2, ignored read and accepted write.
    add(0, 0, 1, 64'h30, 0, 0, 0, 0, 1, 64'h30, 0, 1, 1, 0);
    add(0, 0, 1, 64'h31, 0, 0, 0, 0, 1, 64'h30, 0, 1, 2, 0);
    add(0, 0, 1, 64'h32, 0, 0, 0, 0, 1, 64'h30, 0, 1, 3, 0);
    add(0, 0, 0, 0, 1, 4, 0, 0, 1, 64'h31, 0, 1, 3, 1);
    add(0, 0, 0, 0, 1, 4, 0, 0, 1, 64'h32, 0, 1, 3, 2);
    add(0, 0, 0, 0, 0, 0, 1, 4, 1, 64'h32, 0, 1, 2, 1);
    add(0, 1, 0, 0, 0, 0, 0, 0, 1, 64'h31, 0, 1, 2, 0);
    add(0, 0, 0, 0, 1, 3, 0, 0, 1, 64'h31, 3, 1, 2, 0);
    add(0, 1, 1, 64'h33, 1, 1, 1, 2, 1, 64'h31, 2, 1, 3, 0);
    add(0, 0, 0, 0, 1, 2, 0, 0, 1, 64'h32, 0, 1, 3, 1);
    add(0, 0, 0, 0, 1, 4, 0, 0, 1, 64'h33, 0, 1, 3, 2);
    add(0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 1, 3, 3);
    add(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 2, 2);
    add(0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 1, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 1, 0, 0);
    // Clear on a full queue with write and commit pending.
    for (int i = 0; i < 8; i++)
      add(0, 0, 1, 64'h50 + i, 0, 0, 0, 0, 1, 64'h50, 0, (i < 7), i + 1, 0);
    add(0, 0, 0, 0, 1, 2, 0, 0, 1, 64'h50, 2, 0, 8, 0);
    add(1, 0, 1, 64'hEE, 1, 1, 1, 4, 0, 0, 0, 1, 0, 0);
    add(0, 0, 1, 64'h77, 0, 0, 0, 0, 1, 64'h77, 0, 1, 1, 0);

    rst_n = 1'b0;
    idle();
    #2;
    check_out("reset", 0, 0, '0, 0, 1, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1 idle();
      #1 check_out("vec", i, vecs[i].ev, vecs[i].ed, vecs[i].es, vecs[i].er,
                   vecs[i].ec, vecs[i].ei);
    end

    // Random traffic against the scoreboard; starts with the 0x77 packet queued.
    q.delete();
    q.push_back(64'h77);
    r_off = 0; r_slot = 0; c_slot = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      vec_t t;
      int pre, cpos_new, rpos;
      bit rdy, vis;
      @(negedge clk);
      if (r_off < q.size())
        check_out("rand", cyc, 1, q[r_off], r_slot, q.size() < int'(Els), q.size(), r_off);
      else
        check_out("rand", cyc, 0, '0, r_slot, q.size() < int'(Els), q.size(), r_off);
      t = '{default: 0};
      t.clr  = ($urandom_range(99, 0) < 2);
      t.roll = ($urandom_range(99, 0) < 5);
      t.v    = ($urandom_range(99, 0) < 60);
      t.d    = {$urandom(), $urandom()};
      t.rd   = ($urandom_range(99, 0) < 50);
      t.rc   = int'($urandom_range(4, 0));
      t.cm   = ($urandom_range(99, 0) < 40);
      t.cc   = int'($urandom_range(4, 0));
      cpos_new = (c_slot + t.cc >= 4) ? 4 : c_slot + t.cc;
      rpos     = r_off * 4 + r_slot;
      if (cpos_new > rpos) t.cm = 0;
      drive(t);
      @(posedge clk);
      #1 idle();
      pre = q.size();
      rdy = (pre < int'(Els));
      vis = (r_off < pre);
`ifdef BP_BE_SLOT_CKPT_FIFO_BYPASS_EN
      if (t.v && rdy) vis = 1;
`endif
      if (t.clr) begin
        q.delete();
        r_off = 0; r_slot = 0; c_slot = 0;
      end else begin
        if (t.v && rdy) q.push_back(t.d);
        if (!t.roll && t.rd && vis && t.rc != 0) begin
          if (r_slot + t.rc >= 4) begin
            r_off++;
            r_slot = 0;
          end else begin
            r_slot += t.rc;
          end
        end
        if (t.cm && t.cc != 0) begin
          if (c_slot + t.cc >= 4) begin
            void'(q.pop_front());
            c_slot = 0;
            r_off--;
          end else begin
            c_slot += t.cc;
          end
        end
        if (t.roll) begin
          r_off = 0;
          r_slot = c_slot;
        end
      end
    end

    // Asynchronous reset mid-cycle takes effect before the next edge.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_out("async_reset", 0, 0, '0, 0, 1, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write into an empty queue: same-cycle visibility depends on the bypass build.
    @(negedge clk);
    f.v_i = 1; f.data_i = 64'h5;
    #1;
`ifdef BP_BE_SLOT_CKPT_FIFO_BYPASS_EN
    check_out("bypass_same", 0, 1, 64'h5, 0, 1, 0, 0);
`else
    check_out("no_bypass_same", 0, 0, '0, 0, 1, 0, 0);
`endif
    @(posedge clk);
    #1 idle();
    #1 check_out("write_next", 0, 1, 64'h5, 0, 1, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
